// File: rtl/apple_iie_timing_pkg.sv
// Shared tick positions and line-count constants for the Apple IIe master timing chain.
// The tick values are offsets into one CPU cycle of 14 master ticks, or 16 for the long cycle.
package apple_iie_timing_pkg;

   localparam int unsigned PHI0_RISE_T   = 7;
   localparam int unsigned Q3_HIGH_T0    = 0;
   localparam int unsigned Q3_HIGH_T1    = 7;
   localparam int unsigned Q3_HIGH_LEN   = 4;
   localparam int unsigned RAS_FALL_T0   = 2;
   localparam int unsigned RAS_FALL_T1   = 9;
   localparam int unsigned CAS_FALL_T0   = 4;
   localparam int unsigned CAS_FALL_T1   = 11;
   localparam int unsigned NORMAL_LAST_T = 13;
   localparam int unsigned LONG_LAST_T   = 15;

   localparam int unsigned NTSC_LINES_PER_FRAME = 262;
   localparam int unsigned PAL_LINES_PER_FRAME  = 312;
   localparam int unsigned DEFAULT_CYCLES_PER_LINE = 65;
   localparam int unsigned DEFAULT_LONG_SLOT       = 64;
   localparam int unsigned DEFAULT_VISIBLE_LINES   = 192;

   typedef logic [3:0] tick_t;

   // One bit per bus strobe, all registered together in the top module.
   typedef struct packed {
      logic phi_0;
      logic q3;
      logic ras_n;
      logic cas_n;
   } strobes_t;

   localparam strobes_t STROBES_RESET = '{phi_0: 1'b0, q3: 1'b1, ras_n: 1'b1, cas_n: 1'b1};

endpackage

// File: rtl/apple_iie_scan_counter.sv
// Horizontal and vertical scan counters, advanced once per CPU cycle by cycle_end.
// long_cycle and vbl_n are registered from the next-state values so they move with the counters.
module apple_iie_scan_counter
   import apple_iie_timing_pkg::*;
#(
   parameter int unsigned CYCLES_PER_LINE = DEFAULT_CYCLES_PER_LINE,
   parameter int unsigned LONG_SLOT       = DEFAULT_LONG_SLOT,
   parameter int unsigned LINES_PER_FRAME = NTSC_LINES_PER_FRAME,
   parameter int unsigned VISIBLE_LINES   = DEFAULT_VISIBLE_LINES
) (
   input  logic       clk_14m,
   input  logic       reset_n,
   input  logic       cycle_end,
   output logic [6:0] h_count,
   output logic [8:0] v_count,
   output logic       long_cycle,
   output logic       vbl_n
);

   localparam logic [6:0] H_LAST = 7'(CYCLES_PER_LINE - 1);
   localparam logic [6:0] H_LONG = 7'(LONG_SLOT);
   localparam logic [8:0] V_LAST = 9'(LINES_PER_FRAME - 1);
   localparam logic [8:0] V_VIS  = 9'(VISIBLE_LINES);

   logic [6:0] h_next;
   logic [8:0] v_next;

   always_comb begin
      h_next = h_count;
      v_next = v_count;
      if (cycle_end) begin
         if (h_count == H_LAST) begin
            h_next = 7'd0;
            v_next = (v_count == V_LAST) ? 9'd0 : v_count + 9'd1;
         end else begin
            h_next = h_count + 7'd1;
         end
      end
   end

   always_ff @(posedge clk_14m or negedge reset_n) begin
      if (!reset_n) begin
         h_count    <= 7'd0;
         v_count    <= 9'd0;
         long_cycle <= 1'b0;
         vbl_n      <= 1'b1;
      end else begin
         h_count    <= h_next;
         v_count    <= v_next;
         long_cycle <= (h_next == H_LONG);
         vbl_n      <= (v_next < V_VIS);
      end
   end

endmodule

// File: rtl/apple_iie_timing_generator.sv
// Master timing generator: divides 14M into the CPU/DRAM strobes and the color reference,
// and drives the video scan counters including the once-per-line stretched CPU cycle.
module apple_iie_timing_generator
   import apple_iie_timing_pkg::*;
#(
   parameter int unsigned CYCLES_PER_LINE = DEFAULT_CYCLES_PER_LINE,
   parameter int unsigned LONG_SLOT       = DEFAULT_LONG_SLOT,
   parameter int unsigned LINES_PER_FRAME = NTSC_LINES_PER_FRAME,
   parameter int unsigned VISIBLE_LINES   = DEFAULT_VISIBLE_LINES
) (
   input  logic       clk_14m,
   input  logic       reset_n,
   output logic       clk_phi_0,
   output logic       clk_q3,
   output logic       pras_n,
   output logic       pcas_n,
   output logic       clk_7m,
   output logic       color_ref,
   output logic [6:0] h_count,
   output logic [8:0] v_count,
   output logic       long_cycle,
   output logic       vbl_n
);

   if (LONG_SLOT >= CYCLES_PER_LINE) begin : g_bad_long_slot
      $error("LONG_SLOT must be below CYCLES_PER_LINE");
   end
   if (VISIBLE_LINES >= LINES_PER_FRAME) begin : g_bad_visible
      $error("VISIBLE_LINES must be below LINES_PER_FRAME");
   end
   if (CYCLES_PER_LINE > 128 || LINES_PER_FRAME > 512) begin : g_bad_width
      $error("scan counter widths exceeded");
   end

   tick_t    t, t_next, last_t;
   logic     cycle_end;
   logic [1:0] d;
   strobes_t strobes_q, strobes_d;

   assign last_t    = long_cycle ? tick_t'(LONG_LAST_T) : tick_t'(NORMAL_LAST_T);
   assign cycle_end = (t == last_t);
   assign t_next    = cycle_end ? tick_t'(0) : t + tick_t'(1);

   // Decode the tick the cycle is about to enter so each strobe flop shows t with no lag.
   // A tick never exceeds the current cycle's last value, so the decode needs no length term.
   always_comb begin
      strobes_d       = STROBES_RESET;
      strobes_d.phi_0 = (t_next >= tick_t'(PHI0_RISE_T));
      strobes_d.q3    = (tick_t'(t_next - tick_t'(Q3_HIGH_T0)) < tick_t'(Q3_HIGH_LEN)) ||
                        (tick_t'(t_next - tick_t'(Q3_HIGH_T1)) < tick_t'(Q3_HIGH_LEN));
      strobes_d.ras_n = !((t_next >= tick_t'(RAS_FALL_T0) && t_next < tick_t'(PHI0_RISE_T)) ||
                          (t_next >= tick_t'(RAS_FALL_T1)));
      strobes_d.cas_n = !((t_next >= tick_t'(CAS_FALL_T0) && t_next < tick_t'(PHI0_RISE_T)) ||
                          (t_next >= tick_t'(CAS_FALL_T1)));
   end

   always_ff @(posedge clk_14m or negedge reset_n) begin
      if (!reset_n) begin
         t         <= tick_t'(0);
         d         <= 2'd0;
         strobes_q <= STROBES_RESET;
      end else begin
         t         <= t_next;
         d         <= d + 2'd1;
         strobes_q <= strobes_d;
      end
   end

   assign clk_phi_0 = strobes_q.phi_0;
   assign clk_q3    = strobes_q.q3;
   assign pras_n    = strobes_q.ras_n;
   assign pcas_n    = strobes_q.cas_n;
   // Free-running divider: 912-tick lines keep color_ref phase fixed at every line start.
   assign clk_7m    = d[0];
   assign color_ref = d[1];

   apple_iie_scan_counter #(
      .CYCLES_PER_LINE(CYCLES_PER_LINE),
      .LONG_SLOT      (LONG_SLOT),
      .LINES_PER_FRAME(LINES_PER_FRAME),
      .VISIBLE_LINES  (VISIBLE_LINES)
   ) u_scan (
      .clk_14m   (clk_14m),
      .reset_n   (reset_n),
      .cycle_end (cycle_end),
      .h_count   (h_count),
      .v_count   (v_count),
      .long_cycle(long_cycle),
      .vbl_n     (vbl_n)
   );

endmodule

// File: tb/tb_apple_iie_timing_generator.sv
// Bench for the timing generator: tick-count model checked every cycle plus directed waveform measurements.
// The frame is shortened to 20 lines so frame wrap fits in a short run.
module tb_apple_iie_timing_generator;

   localparam int unsigned CPL        = 65;
   localparam int unsigned LPF        = 20;
   localparam int unsigned VIS        = 12;
   localparam int unsigned LINE_TICKS = (CPL - 1) * 14 + 16;

   logic       clk_14m = 1'b0;
   logic       reset_n = 1'b0;
   logic       clk_phi_0, clk_q3, pras_n, pcas_n, clk_7m, color_ref, long_cycle, vbl_n;
   logic [6:0] h_count;
   logic [8:0] v_count;

   int          checks = 0;
   int          failures = 0;
   int          printed = 0;
   bit          chk_en = 1'b0;
   int unsigned n = 0;
   logic [15:0] exp_q[$];

   apple_iie_timing_generator #(
      .CYCLES_PER_LINE(CPL),
      .LONG_SLOT      (CPL - 1),
      .LINES_PER_FRAME(LPF),
      .VISIBLE_LINES  (VIS)
   ) dut (
      .clk_14m   (clk_14m),
      .reset_n   (reset_n),
      .clk_phi_0 (clk_phi_0),
      .clk_q3    (clk_q3),
      .pras_n    (pras_n),
      .pcas_n    (pcas_n),
      .clk_7m    (clk_7m),
      .color_ref (color_ref),
      .h_count   (h_count),
      .v_count   (v_count),
      .long_cycle(long_cycle),
      .vbl_n     (vbl_n)
   );

   // clock / reset
   always #5 clk_14m = ~clk_14m;

   // Model state: master ticks elapsed since reset release.
   always @(posedge clk_14m or negedge reset_n) begin
      if (!reset_n) n <= 0;
      else          n <= n + 1;
   end

   function automatic logic [23:0] model_word(input int unsigned ticks);
      int unsigned p, h, t, v;
      logic phi, q3, ras, cas, lng, vbl;
      p = ticks % LINE_TICKS;
      v = (ticks / LINE_TICKS) % LPF;
      if (p < (CPL - 1) * 14) begin
         h = p / 14;
         t = p % 14;
      end else begin
         h = CPL - 1;
         t = p - (CPL - 1) * 14;
      end
      phi = (t >= 7);
      q3  = (t <= 3) || (t >= 7 && t <= 10);
      ras = !((t >= 2 && t <= 6) || t >= 9);
      cas = !((t >= 4 && t <= 6) || t >= 11);
      lng = (h == CPL - 1);
      vbl = (v < VIS);
      return {phi, q3, ras, cas, ticks[0], ticks[1], lng, vbl, 7'(h), 9'(v)};
   endfunction

   // scoreboard: every cycle against the model
   always @(negedge clk_14m) begin
      if (chk_en) begin
         logic [23:0] act, exp;
         act = {clk_phi_0, clk_q3, pras_n, pcas_n, clk_7m, color_ref, long_cycle, vbl_n,
                h_count, v_count};
         exp = model_word(n);
         checks++;
         if (act !== exp) begin
            failures++;
            if (printed < 20) begin
               printed++;
               $display("FAIL cycle_outputs n=%0d actual=%h expected=%h", n, act, exp);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic check_q(input string name, input int act);
      int exp;
      exp = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
      check(name, act, exp);
   endtask

   // driver tasks
   task automatic assert_reset_now();
      reset_n = 1'b0;
      #1;
      check("rst_phi0", clk_phi_0, 0);
      check("rst_q3", clk_q3, 1);
      check("rst_pras", pras_n, 1);
      check("rst_pcas", pcas_n, 1);
      check("rst_h", h_count, 0);
      check("rst_v", v_count, 0);
      check("rst_long", long_cycle, 0);
   endtask

   task automatic release_reset(input int hold);
      repeat (hold) @(posedge clk_14m);
      @(negedge clk_14m);
      #1 reset_n = 1'b1;
   endtask

   task automatic wait_h(input int target, output bit ok);
      int guard = 0;
      while (h_count != 7'(target) && guard < 20000) begin
         @(negedge clk_14m);
         guard++;
      end
      ok = (guard < 20000);
   endtask

   task automatic measure_cycle(input int h_target, input bit aligned, input string tag);
      int len = 0, phi_hi = 0, q3_hi = 0, ras_lo = 0, cas_lo = 0, long_hi = 0, guard = 0;
      bit ok = 1'b1;
      if (!aligned) begin
         @(negedge clk_14m);
         while (h_count == 7'(h_target) && guard < 2000) begin @(negedge clk_14m); guard++; end
         wait_h(h_target, ok);
      end
      while (ok && h_count == 7'(h_target) && guard < 2000) begin
         len++;
         phi_hi  += int'(clk_phi_0);
         q3_hi   += int'(clk_q3);
         ras_lo  += int'(!pras_n);
         cas_lo  += int'(!pcas_n);
         long_hi += int'(long_cycle);
         @(negedge clk_14m);
         guard++;
      end
      if (!ok || guard >= 2000) check({tag, "_timeout"}, 0, 1);
      check_q({tag, "_len"}, len);
      check_q({tag, "_phi_hi"}, phi_hi);
      check_q({tag, "_q3_hi"}, q3_hi);
      check_q({tag, "_ras_lo"}, ras_lo);
      check_q({tag, "_cas_lo"}, cas_lo);
      check_q({tag, "_long_hi"}, long_hi);
   endtask

   initial begin : stimulus
      int  k;
      bit  ok;
      int  rises;
      logic prev;
      int  prev_h;

      // reset held 5 ticks, then count ticks to the first phi_0 rise
      repeat (5) @(posedge clk_14m);
      @(negedge clk_14m);
      chk_en = 1'b1;
      #1 reset_n = 1'b1;
      k = 0;
      while (!clk_phi_0 && k < 20) begin @(negedge clk_14m); k++; end
      check("first_phi_rise", k, 7);

      // normal cycle, long cycle, and the normal cycle that follows
      exp_q = '{16'd14, 16'd7, 16'd8, 16'd10, 16'd6, 16'd0};
      measure_cycle(10, 1'b0, "h10");
      exp_q = '{16'd16, 16'd9, 16'd8, 16'd12, 16'd8, 16'd16};
      measure_cycle(64, 1'b0, "h64");
      exp_q = '{16'd14, 16'd7, 16'd8, 16'd10, 16'd6, 16'd0};
      measure_cycle(0, 1'b1, "h0_after_long");

      // color lock over three consecutive lines
      wait_h(64, ok);
      wait_h(0, ok);
      for (int line = 0; line < 3; line++) begin
         check("color_at_line_start", color_ref, 0);
         prev = color_ref;
         rises = 0;
         for (int i = 0; i < int'(LINE_TICKS); i++) begin
            @(negedge clk_14m);
            if (color_ref && !prev) rises++;
            prev = color_ref;
         end
         check("color_rises_per_line", rises, 228);
      end
      check("color_line_start_h", h_count, 0);

      // randomized mid-operation resets
      for (int r = 0; r < 4; r++) begin
         repeat ($urandom_range(50, 2000)) @(negedge clk_14m);
         #($urandom_range(1, 4));
         assert_reset_now();
         release_reset($urandom_range(1, 8));
      end

      // reset at t=12 of a long cycle
      @(negedge clk_14m);
      while (h_count == 7'd64) @(negedge clk_14m);
      wait_h(64, ok);
      if (!ok) check("long_wait_timeout", 0, 1);
      repeat (12) @(negedge clk_14m);
      check("pre_rst_phi0", clk_phi_0, 1);
      check("pre_rst_pcas", pcas_n, 0);
      #2;
      assert_reset_now();
      release_reset($urandom_range(2, 6));
      repeat (3) @(negedge clk_14m);
      check("restart_h", h_count, 0);

      // frame boundaries
      wait_h(0, ok);
      k = 0;
      while (v_count != 9'(VIS - 1) && k < 30000) begin @(negedge clk_14m); k++; end
      check("vbl_last_visible", vbl_n, 1);
      while (v_count != 9'(VIS) && k < 30000) begin @(negedge clk_14m); k++; end
      check("vbl_first_blank", vbl_n, 0);
      while (v_count != 9'(LPF - 1) && k < 30000) begin @(negedge clk_14m); k++; end
      prev_h = h_count;
      while (v_count != 9'd0 && k < 30000) begin
         prev_h = h_count;
         @(negedge clk_14m);
         k++;
      end
      if (k >= 30000) check("frame_timeout", 0, 1);
      check("wrap_prev_h", prev_h, 64);
      check("wrap_h", h_count, 0);
      check("wrap_vbl", vbl_n, 1);
      repeat (100) @(negedge clk_14m);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
